// File: rtl/lsu_mem_master_pkg.sv
// Shared encodings and memory map for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } lsu_state_e;

  localparam logic [31:0] ROM_BASE    = 32'h0000_0000;
  localparam logic [31:0] ROM_END     = 32'h0001_FFFF;
  localparam logic [31:0] SRAM_BASE   = 32'h0002_0000;
  localparam logic [31:0] SRAM_END    = 32'h0002_FFFF;
  localparam logic [31:0] PERIPH_BASE = 32'h0003_0000;
  localparam logic [31:0] PERIPH_END  = 32'h0003_FFFF;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return ((size == SZ_HALF) && a[0]) || ((size == SZ_WORD) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Request/response channels and memory port of the LSU, bundled.
interface lsu_mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic        mem_w_en;
  logic [31:0] mem_base_addr;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data;

  modport master (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready, mem_r_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_w_en, mem_base_addr, mem_w_data
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready, mem_r_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_w_en, mem_base_addr, mem_w_data
  );
endinterface

// File: rtl/lsu_byte_lane.sv
// Sub-word lane handling: load extract/extend and store merge into a memory word.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b          = word[{lane, 3'b000} +: 8];
    h          = word[{lane[1], 4'b0000} +: 16];
    load_data  = word;
    merge_data = word;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{sgn & b[7]}}, b};
        merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data = {{16{sgn & h[15]}}, h};
        merge_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store unit driving a combinational-read word memory.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter logic [31:0] ROM_TOP = ROM_END,
  parameter logic [31:0] MEM_TOP = PERIPH_END
) (
  input  logic             clk,
  input  logic             rst,
  lsu_mem_master_if.master bus
);

  lsu_state_e  state, nxt;
  logic [31:0] addr_q, wdata_q, merge_q, rdata_q;
  logic [1:0]  size_q;
  logic        sgn_q, wr_q, fault_q;
  logic        req_fault;
  logic [31:0] load_data, merge_data;

  // Fault decode runs on the incoming request so a fault answers one cycle after accept.
  assign req_fault = (bus.req_size == SZ_RSVD) ||
                     misaligned(bus.req_size, bus.req_addr[1:0]) ||
                     (bus.req_addr > MEM_TOP) ||
                     (bus.req_write && (bus.req_addr <= ROM_TOP));

  lsu_byte_lane u_lane (
    .word       (bus.mem_r_data),
    .lane       (addr_q[1:0]),
    .size       (size_q),
    .sgn        (sgn_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (bus.req_valid) begin
                  if (req_fault)                                    nxt = ST_RESP;
                  else if (bus.req_write && bus.req_size == SZ_WORD) nxt = ST_WRITE;
                  else                                               nxt = ST_READ;
                end
      ST_READ:  nxt = wr_q ? ST_WRITE : ST_RESP;
      ST_WRITE: nxt = ST_RESP;
      ST_RESP:  if (bus.rsp_ready) nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      size_q  <= SZ_BYTE;
      sgn_q   <= 1'b0;
      wr_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      if (state == ST_IDLE && bus.req_valid) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        size_q  <= bus.req_size;
        sgn_q   <= bus.req_signed;
        wr_q    <= bus.req_write;
        fault_q <= req_fault;
        rdata_q <= '0;
      end else if (state == ST_READ) begin
        if (wr_q) merge_q <= merge_data;
        else      rdata_q <= load_data;
      end
    end
  end

  // Memory-side outputs decode purely from registered state and fields.
  always_comb begin
    bus.req_ready     = (state == ST_IDLE);
    bus.rsp_valid     = (state == ST_RESP);
    bus.rsp_rdata     = rdata_q;
    bus.rsp_fault     = fault_q;
    bus.mem_w_en      = (state == ST_WRITE);
    bus.mem_base_addr = '0;
    bus.mem_w_data    = '0;
    if (state == ST_READ || state == ST_WRITE) bus.mem_base_addr = {addr_q[31:2], 2'b00};
    if (state == ST_WRITE) bus.mem_w_data = (size_q == SZ_WORD) ? wdata_q : merge_q;
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master against a small word memory model.
module tb_lsu_mem_master;
  import lsu_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          we;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  int   acc_cyc = 0;
  int   we_cnt = 0;
  int   lat_obs = 0;
  bit   seen = 1'b0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] mem [64];
  exp_t sb[$];

  lsu_mem_master_if bus ();

  lsu_mem_master #(.ROM_TOP(32'h0001FFFF), .MEM_TOP(32'h0003FFFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.mem_r_data = mem[bus.mem_base_addr[7:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
    end else if (bus.mem_w_en) begin
      mem[bus.mem_base_addr[7:2]] <= bus.mem_w_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp_v);
    end
  endtask

  // Monitor: measures latency and write strobes, pops the scoreboard on each consumed response.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.req_valid && bus.req_ready) begin
          acc_cyc = cyc;
          we_cnt  = 0;
        end
        if (bus.mem_w_en) begin
          we_cnt++;
          wr_addr = bus.mem_base_addr;
          wr_data = bus.mem_w_data;
        end
        if (bus.rsp_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            if (!seen) begin
              lat_obs = cyc - acc_cyc;
              seen    = 1'b1;
            end
            chk("rsp_rdata", bus.rsp_rdata, sb[0].rdata);
            if (bus.rsp_ready) begin
              chk("rsp_fault", 32'(bus.rsp_fault), 32'(sb[0].fault));
              chk("latency", 32'(lat_obs), 32'(sb[0].lat));
              chk("w_en_count", 32'(we_cnt), 32'(sb[0].we));
              void'(sb.pop_front());
              seen = 1'b0;
            end
          end
        end
      end else begin
        seen = 1'b0;
      end
    end
  end

  task automatic push(input logic [31:0] rd, input logic f, input int lat, input int we);
    exp_t e;
    e.rdata = rd; e.fault = f; e.lat = lat; e.we = we;
    sb.push_back(e);
  endtask

  task automatic drive(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
  endtask

  task automatic wait_accept();
    int n = 0;
    bit ok = 1'b0;
    while (n < 40 && !ok) begin
      @(negedge clk);
      if (bus.req_ready) ok = 1'b1;
      n++;
    end
    if (!ok) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 40 && sb.size() != 0) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("rsp_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    #1;
  endtask

  task automatic xfer(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd, input logic f,
                      input int lat, input int we);
    push(rd, f, lat, we);
    drive(w, sz, sg, a, wd);
    wait_accept();
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst = 1'b0;
    mem_init = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size = SZ_WORD;
    bus.req_signed = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_fault", 32'(bus.rsp_fault), 32'd0);
    chk("rst_w_en", 32'(bus.mem_w_en), 32'd0);
    chk("rst_base_addr", bus.mem_base_addr, 32'd0);
    chk("rst_w_data", bus.mem_w_data, 32'd0);
    mem_init = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // Word round trip
    xfer(1, SZ_WORD, 0, 32'h0002_0010, 32'h98BA_DCFF, 32'h0, 0, 2, 1);
    chk("wr_addr_word", wr_addr, 32'h0002_0010);
    chk("wr_data_word", wr_data, 32'h98BA_DCFF);
    xfer(0, SZ_WORD, 0, 32'h0002_0010, 32'h0, 32'h98BA_DCFF, 0, 2, 0);

    // Extensions
    xfer(0, SZ_BYTE, 1, 32'h0002_0011, 32'h0, 32'hFFFF_FFDC, 0, 2, 0);
    xfer(0, SZ_BYTE, 0, 32'h0002_0011, 32'h0, 32'h0000_00DC, 0, 2, 0);
    xfer(0, SZ_HALF, 1, 32'h0002_0012, 32'h0, 32'hFFFF_98BA, 0, 2, 0);
    xfer(0, SZ_HALF, 0, 32'h0002_0012, 32'h0, 32'h0000_98BA, 0, 2, 0);

    // Sub-word store: read-modify-write
    xfer(1, SZ_BYTE, 0, 32'h0002_0013, 32'h0000_0055, 32'h0, 0, 3, 1);
    chk("wr_addr_byte", wr_addr, 32'h0002_0010);
    chk("wr_data_byte", wr_data, 32'h55BA_DCFF);
    xfer(0, SZ_WORD, 0, 32'h0002_0010, 32'h0, 32'h55BA_DCFF, 0, 2, 0);
    xfer(1, SZ_HALF, 0, 32'h0002_0016, 32'h0000_BEEF, 32'h0, 0, 3, 1);
    chk("wr_data_half", wr_data, 32'hBEEF_0005);

    // Faults
    xfer(0, SZ_HALF, 0, 32'h0002_0011, 32'h0, 32'h0, 1, 1, 0);
    xfer(0, SZ_RSVD, 0, 32'h0002_0010, 32'h0, 32'h0, 1, 1, 0);
    xfer(1, SZ_WORD, 0, 32'h0000_0100, 32'h1111_2222, 32'h0, 1, 1, 0);
    xfer(0, SZ_WORD, 0, 32'h0004_0000, 32'h0, 32'h0, 1, 1, 0);
    xfer(0, SZ_WORD, 0, 32'h0003_FFFC, 32'h0, mem[63], 0, 2, 0);

    // Backpressure with a held second request
    bus.rsp_ready = 1'b0;
    push(32'h55BA_DCFF, 0, 2, 0);
    drive(0, SZ_WORD, 0, 32'h0002_0010, 32'h0);
    wait_accept();
    push(32'h0000_00FF, 0, 2, 0);
    drive(0, SZ_BYTE, 0, 32'h0002_0010, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    k = cyc;
    wait_accept();
    chk("bp_accept_cycle", 32'(acc_cyc), 32'(k + 1));
    wait_idle();

    // Reset during WRITE must not commit
    drive(1, SZ_WORD, 0, 32'h0002_0020, 32'h1234_5678);
    wait_accept();
    chk("pre_rst_w_en", 32'(bus.mem_w_en), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_w_en", 32'(bus.mem_w_en), 32'd0);
    chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_base_addr", bus.mem_base_addr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mem_after_rst", mem[8], 32'hA5A5_0008);
    @(posedge clk); #1;
    xfer(0, SZ_WORD, 0, 32'h0002_0020, 32'h0, 32'hA5A5_0008, 0, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store unit that acts as the initiator on the 32-bit byte-addressed memory port (`w_en`/`base_addr`/`w_data`/`r_data`).

- Sits between the Cortex-M0 execute stage and the memory.
- Accepts one load or store at a time over a valid/ready request channel.
- Handles byte, halfword and word sizes, building sub-word stores as read-modify-write.
- Sign/zero-extends loads and returns the result or a fault on a valid/ready response channel.
- Enforces alignment and the ROM/SRAM/peripheral map.

## Interface
Parameters:
- `ROM_TOP`, 32'h0001FFFF: last ROM address; stores at or below it fault.
- `MEM_TOP`, 32'h0003FFFF: last mapped address; any access above it faults.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved (faults).
- `req_signed`  in  1  sign-extend load; ignored for stores.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_rdata`  out  32  load result; 0 for stores and faults.
- `rsp_fault`  out  1  misaligned, reserved size, unmapped, or ROM store.
- `mem_w_en`  out  1  memory write strobe.
- `mem_base_addr`  out  32  word-aligned address to memory.
- `mem_w_data`  out  32  memory write data.
- `mem_r_data`  in  32  memory read data, combinational from `mem_base_addr`.

## Operation
- States: IDLE, READ, WRITE, RESP; the state register is reset to IDLE.
- **IDLE**
  - Handshake occurs when `req_valid && req_ready`.
  - On handshake, latch addr/size/signed/write/wdata.
  - Fault check on the latched request; any true → RESP with fault=1 and no memory access:
    - size==11;
    - half with addr[0]≠0;
    - word with addr[1:0]≠0;
    - addr>`MEM_TOP`;
    - store with addr≤`ROM_TOP`.
  - Otherwise: load or sub-word store → READ; word store → WRITE.
- **READ**
  - `mem_base_addr`={addr[31:2],2'b00}.
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Load: extract lane, extend per `req_signed` (word ignores it), register into `rsp_rdata`, then → RESP.
  - Sub-word store: register a merge buffer = `mem_r_data` with the addressed lane replaced by `req_wdata[7:0]` / `[15:0]`, then → WRITE.
- **WRITE**
  - `mem_w_en`=1.
  - `mem_base_addr` aligned.
  - `mem_w_data` = merge buffer, or `req_wdata` for a word store.
  - Memory commits at the rising edge leaving WRITE, then → RESP.
- **RESP**
  - `rsp_valid`=1; `rsp_rdata`/`rsp_fault` are held stable.
  - → IDLE on `rsp_ready`.
  - A new request is not accepted in the same cycle.
- Outside READ/WRITE: `mem_base_addr`=0. Outside WRITE: `mem_w_en`=0 and `mem_w_data`=0. All three decode from registered state, so they are glitch-free.
- Address compares are unsigned 32-bit. The aligned address never wraps because `MEM_TOP` < 2^32−4.

## Timing
- Reset values:
  - `req_ready`=1.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_fault`=0.
  - `mem_w_en`=0, `mem_base_addr`=0, `mem_w_data`=0.
- Latency from the accept edge to `rsp_valid` high:
  - fault: 1 cycle;
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles.
- `mem_w_en` is high for exactly one cycle per non-faulting store and never for loads.
- Back-to-back throughput: one request per (latency + 1) cycles with `rsp_ready` held high.
- Reset asserted mid-operation:
  - State goes to IDLE immediately and outputs take their reset values.
  - A WRITE aborted before its edge does not commit.
  - The pending response is discarded.

## Structure
- Package `lsu_pkg`:
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`;
  - state enum;
  - memory-map constants (ROM/SRAM/peripheral base and top).
- Sub-module `lsu_byte_lane` (combinational):
  - load extraction/extension from (word, addr[1:0], size, signed);
  - store merge from (word, wdata, addr[1:0], size).
  - Instantiated once; the FSM stays in the top.

## Test plan
- **Word round trip.** Word store 0x98BADCFF @0x00020010, then word load.
  - Both are 2-cycle responses.
  - `mem_w_en` is high one cycle with `mem_base_addr`=0x00020010.
  - Load returns 0x98BADCFF, fault=0.
- **Extensions.** Same data:
  - signed byte @0x00020011 → 0xFFFFFFDC;
  - unsigned byte → 0x000000DC;
  - signed half @0x00020012 → 0xFFFF98BA;
  - unsigned half → 0x000098BA.
- **Sub-word store.** Byte store 0x55 @0x00020013.
  - READ then WRITE with `mem_w_data`=0x55BADCFF; latency 3.
  - A following word load returns 0x55BADCFF.
- **Faults.** Each gives fault=1, rdata=0, 1-cycle latency and no `mem_w_en`:
  - half load @0x00020011;
  - size=11;
  - word store @0x00000100;
  - word load @0x00040000.
- **Backpressure.** `rsp_ready` low for 5 cycles.
  - `rsp_valid`/`rsp_rdata` stay stable.
  - `req_ready`=0, and a held `req_valid` is not accepted until the cycle after `rsp_ready`.
- **Reset mid-store.** `rst` low during WRITE of store 0x12345678 @0x00020020.
  - `mem_w_en` drops immediately; `req_ready`=1, `rsp_valid`=0.
  - Memory word remains at its prior value.
